// File: rtl/uart_tx_engine.sv
// UART transmit engine: start, 5..DATA_MAX data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to build the parity generator and PARITY state; otherwise cfg_parity is ignored.
module uart_tx_engine #(
    parameter int DATA_MAX = 9,
    parameter int OVS      = 16,
    parameter int OVS_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [DATA_MAX-1:0] tx_data,
    input  logic [3:0]          cfg_data_bits,
    input  logic [1:0]          cfg_parity,
    input  logic                cfg_stop2,
    output logic                tx_out,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state, state_d;
    logic [OVS_W-1:0]    bit_cnt, bit_cnt_d;
    logic [3:0]          data_cnt, data_cnt_d;
    logic                stop_cnt, stop_cnt_d;
    logic [DATA_MAX-1:0] shift_reg, shift_d;
    logic [3:0]          lat_n, n_d;
    logic                lat_stop2, stop2_d;
    logic [3:0]          n_clamped;
    logic                bit_end;
    logic                last_stop;
    logic                transfer;
    logic                tx_out_d;
    logic                busy_d;
    logic                done_d;

`ifdef UART_TX_PARITY_EN
    logic par_en, par_en_d, par_bit, par_bit_d;
    logic par_en_calc, par_bit_calc;
`else
    logic unused_cfg_parity;
    assign unused_cfg_parity = ^cfg_parity;
`endif

    always_comb begin
        if (cfg_data_bits < 4'd5)
            n_clamped = 4'd5;
        else if (cfg_data_bits > 4'(DATA_MAX))
            n_clamped = 4'(DATA_MAX);
        else
            n_clamped = cfg_data_bits;
    end

`ifdef UART_TX_PARITY_EN
    // Parity covers only the bits that will actually be sent, so it is computed from the clamped length.
    always_comb begin
        par_bit_calc = 1'b0;
        for (int i = 0; i < DATA_MAX; i++)
            if (4'(i) < n_clamped)
                par_bit_calc = par_bit_calc ^ tx_data[i];
        par_bit_calc = par_bit_calc ^ (cfg_parity == 2'b10);
        par_en_calc  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
    end
`endif

    assign bit_end   = (bit_cnt == OVS_W'(OVS - 1));
    assign last_stop = (state == STOP) && bit_end && (stop_cnt == lat_stop2);
    assign tx_ready  = !rst && ((state == IDLE) || last_stop);
    assign transfer  = tx_valid && tx_ready;

    // NOTE: every variable gets its hold value first, so no path through the case leaves one unassigned (no latch).
    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        data_cnt_d = data_cnt;
        stop_cnt_d = stop_cnt;
        shift_d    = shift_reg;
        n_d        = lat_n;
        stop2_d    = lat_stop2;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en;
        par_bit_d  = par_bit;
`endif

        case (state)
            IDLE: ;
            START: begin
                if (bit_end) begin
                    state_d    = DATA;
                    bit_cnt_d  = '0;
                    data_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt + OVS_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    shift_d   = shift_reg >> 1;
                    if (data_cnt == lat_n - 4'd1) begin
`ifdef UART_TX_PARITY_EN
                        state_d = par_en ? PARITY : STOP;
`else
                        state_d = STOP;
`endif
                        stop_cnt_d = 1'b0;
                    end else begin
                        data_cnt_d = data_cnt + 4'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt + OVS_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                end else begin
                    bit_cnt_d = bit_cnt + OVS_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (stop_cnt == lat_stop2)
                        state_d = IDLE;
                    else
                        stop_cnt_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt + OVS_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                bit_cnt_d  = '0;
                data_cnt_d = '0;
                stop_cnt_d = 1'b0;
            end
        endcase

        // A transfer on the last stop cycle overrides the return to IDLE for zero-gap frames.
        if (transfer) begin
            state_d    = START;
            bit_cnt_d  = '0;
            data_cnt_d = '0;
            stop_cnt_d = 1'b0;
            shift_d    = tx_data;
            n_d        = n_clamped;
            stop2_d    = cfg_stop2;
`ifdef UART_TX_PARITY_EN
            par_en_d   = par_en_calc;
            par_bit_d  = par_bit_calc;
`endif
        end
    end

    // Registered outputs are decoded from next-state values so they line up with the state they describe.
    always_comb begin
        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_out_d = par_bit_d;
`endif
            default: tx_out_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (bit_cnt_d == OVS_W'(OVS - 1)) && (stop_cnt_d == stop2_d);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            data_cnt  <= '0;
            stop_cnt  <= 1'b0;
            shift_reg <= '0;
            lat_n     <= '0;
            lat_stop2 <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en    <= 1'b0;
            par_bit   <= 1'b0;
`endif
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            data_cnt  <= data_cnt_d;
            stop_cnt  <= stop_cnt_d;
            shift_reg <= shift_d;
            lat_n     <= n_d;
            lat_stop2 <= stop2_d;
`ifdef UART_TX_PARITY_EN
            par_en    <= par_en_d;
            par_bit   <= par_bit_d;
`endif
            tx_out    <= tx_out_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: table of frame formats plus back-to-back and mid-frame reset sequences.
module tb_uart_tx_engine;
    localparam int DATA_MAX = 9;
    localparam int OVS      = 16;
    localparam int OVS_W    = 4;

`ifdef UART_TX_PARITY_EN
    localparam bit P_BUILD = 1'b1;
`else
    localparam bit P_BUILD = 1'b0;
`endif

    typedef struct {
        logic [DATA_MAX-1:0] data;
        logic [3:0]          nbits_cfg;
        logic [1:0]          par;
        logic                stop2;
        int                  n_eff;
        logic                par_bit;
        int                  len_p;
        int                  len_np;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                tx_valid = 1'b0;
    logic                tx_ready;
    logic [DATA_MAX-1:0] tx_data = '0;
    logic [3:0]          cfg_data_bits = 4'd8;
    logic [1:0]          cfg_parity = 2'b00;
    logic                cfg_stop2 = 1'b0;
    logic                tx_out;
    logic                busy;
    logic                done;

    int n_checks = 0;
    int n_pass   = 0;

    vec_t vecs[8];

    uart_tx_engine #(.DATA_MAX(DATA_MAX), .OVS(OVS), .OVS_W(OVS_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .tx_out        (tx_out),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic logic exp_bit(input vec_t v, input int b, input bit p_en);
        if (b == 0)
            return 1'b0;
        if (b <= v.n_eff)
            return v.data[b-1];
        if (p_en && b == v.n_eff + 1)
            return v.par_bit;
        return 1'b1;
    endfunction

    task automatic apply(input vec_t v);
        tx_valid      = 1'b1;
        tx_data       = v.data;
        cfg_data_bits = v.nbits_cfg;
        cfg_parity    = v.par;
        cfg_stop2     = v.stop2;
    endtask

    // Called at a negedge with tx_valid already high; returns right after the transfer edge.
    task automatic wait_transfer(input string tag);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s ready before transfer", tag), int'(tx_ready === 1'b1), 1);
        @(posedge clk);
        #1;
    endtask

    // Samples cycles T+1..T+len at negedges; leaves time at the negedge of the last frame cycle.
    task automatic check_frame(input vec_t v, input string tag);
        bit   p_en;
        int   len, nbits, k, done_cnt, done_at, busy_bad, ready_bad;
        logic e, obs;
        p_en      = P_BUILD && (v.par == 2'b01 || v.par == 2'b10);
        len       = p_en ? v.len_p : v.len_np;
        nbits     = len / OVS;
        done_cnt  = 0;
        done_at   = -1;
        busy_bad  = 0;
        ready_bad = 0;
        for (int b = 0; b < nbits; b++) begin
            e   = exp_bit(v, b, p_en);
            obs = e;
            for (int c = 0; c < OVS; c++) begin
                @(negedge clk);
                k = b * OVS + c + 1;
                if (tx_out !== e) obs = ~e;
                if (done === 1'b1) begin
                    done_cnt++;
                    if (done_at < 0) done_at = k;
                end
                if (busy !== 1'b1) busy_bad++;
                if (tx_ready !== (k == len)) ready_bad++;
            end
            check($sformatf("%s tx_out bit %0d", tag, b), int'(obs), int'(e));
        end
        check($sformatf("%s done count", tag), done_cnt, 1);
        check($sformatf("%s done cycle", tag), done_at, len);
        check($sformatf("%s busy low cycles", tag), busy_bad, 0);
        check($sformatf("%s ready wrong cycles", tag), ready_bad, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        apply(v);
        wait_transfer(tag);
        // Scramble every input after the transfer; the frame must use only latched values.
        tx_valid      = 1'b0;
        tx_data       = ~v.data;
        cfg_data_bits = 4'd9;
        cfg_parity    = 2'b01;
        cfg_stop2     = ~v.stop2;
        check_frame(v, tag);
        @(negedge clk);
        check($sformatf("%s idle tx_out", tag), int'(tx_out), 1);
        check($sformatf("%s idle busy", tag), int'(busy), 0);
        check($sformatf("%s idle ready", tag), int'(tx_ready), 1);
    endtask

    initial begin
        vec_t va, vb;
        int   done_seen, line_low;

        //                data     cfg    par    stop  n  pbit  len_p len_np
        vecs[0] = '{9'h0A5, 4'd8,  2'b00, 1'b0, 8, 1'b0, 160, 160};
        vecs[1] = '{9'h007, 4'd8,  2'b01, 1'b0, 8, 1'b1, 176, 160};
        vecs[2] = '{9'h007, 4'd8,  2'b10, 1'b0, 8, 1'b0, 176, 160};
        vecs[3] = '{9'h055, 4'd7,  2'b10, 1'b1, 7, 1'b1, 176, 160};
        vecs[4] = '{9'h0D3, 4'd3,  2'b01, 1'b0, 5, 1'b1, 128, 112};
        vecs[5] = '{9'h1FF, 4'd15, 2'b00, 1'b0, 9, 1'b0, 176, 176};
        vecs[6] = '{9'h12C, 4'd9,  2'b10, 1'b1, 9, 1'b1, 208, 192};
        vecs[7] = '{9'h03C, 4'd8,  2'b11, 1'b0, 8, 1'b0, 160, 160};

        // Reset state, including tx_ready forced low while rst is high.
        repeat (3) @(negedge clk);
        check("reset tx_out", int'(tx_out), 1);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset ready forced low", int'(tx_ready), 0);
        rst = 1'b0;
        #1;
        check("ready after reset release", int'(tx_ready), 1);

        for (int i = 0; i < 8; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: tx_valid held high across two queued frames.
        va = '{9'h03C, 4'd8, 2'b00, 1'b0, 8, 1'b0, 160, 160};
        vb = '{9'h0C3, 4'd8, 2'b00, 1'b0, 8, 1'b0, 160, 160};
        @(negedge clk);
        apply(va);
        wait_transfer("b2b first");
        tx_data = vb.data;
        check_frame(va, "b2b first");
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        check_frame(vb, "b2b second");
        @(negedge clk);
        check("b2b idle busy", int'(busy), 0);

        // Reset for one cycle during the 4th data bit (frame cycles 65..80).
        va = '{9'h0A5, 4'd8, 2'b00, 1'b0, 8, 1'b0, 160, 160};
        @(negedge clk);
        apply(va);
        wait_transfer("rst frame");
        tx_valid = 1'b0;
        repeat (70) @(negedge clk);
        check("rst frame 4th data bit", int'(tx_out), 0);
        check("rst frame busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("ready low during mid-frame rst", int'(tx_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("after rst tx_out", int'(tx_out), 1);
        check("after rst busy", int'(busy), 0);
        check("after rst done", int'(done), 0);
        check("after rst ready", int'(tx_ready), 1);
        done_seen = 0;
        line_low  = 0;
        repeat (120) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
            if (tx_out !== 1'b1) line_low++;
        end
        check("abandoned frame done pulses", done_seen, 0);
        check("abandoned frame line not idle", line_low, 0);
        vb = '{9'h05A, 4'd8, 2'b01, 1'b1, 8, 1'b0, 192, 176};
        run_vec(vb, "post-rst frame");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
